rca_seq_accum: RTL and testbench

Multi-cycle wide adder/accumulator controller for the MAC datapath. It shares one narrow CHUNK_W ripple-carry adder across a TOTAL_W operand, one chunk per clock, LSB chunk first, with the carry held in a register between chunks. It supports add, subtract and accumulate-into-register, and uses valid/ready handshakes on both the input and output sides.

---
 rtl/rca_seq_accum_pkg.sv | 19 +
 rtl/rca_seq_accum_rca.sv | 27 ++
 rtl/rca_seq_accum.sv | 142 ++++++++++++++
 tb/tb_rca_seq_accum.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rca_seq_accum_pkg.sv
// rca_seq_accum shared definitions.
// FSM encoding, default widths and index sizing helper.
package rca_seq_accum_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int TOTAL_W_DEF = 32;
  localparam int CHUNK_W_DEF = 8;

  // Chunk index width; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rca_seq_accum_rca.sv
// Narrow ripple-carry adder slice.
// Shared by the sequential accumulator, one chunk per clock.
module rca_seq_accum_rca
  import rca_seq_accum_pkg::*;
#(
  parameter int WIDTH = CHUNK_W_DEF
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  // Bit-serial carry chain through full adders.
  always_comb begin
    logic c;
    c = i_cin;
    o_sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ c;
      c = (i_a[i] & i_b[i]) | (c & (i_a[i] ^ i_b[i]));
    end
    o_cout = c;
  end

endmodule

// File: rtl/rca_seq_accum.sv
// Multi-cycle wide add/sub/accumulate controller.
// One CHUNK_W slice is reused LSB chunk first.
module rca_seq_accum
  import rca_seq_accum_pkg::*;
#(
  parameter int TOTAL_W = TOTAL_W_DEF,
  parameter int CHUNK_W = CHUNK_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [TOTAL_W-1:0] in_a,
  input  logic [TOTAL_W-1:0] in_b,
  input  logic               in_sub,
  input  logic               in_acc,
  input  logic               acc_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [TOTAL_W-1:0] out_sum,
  output logic               out_cout,
  output logic               out_ovf,
  output logic               busy
);

  localparam int NCHUNK = TOTAL_W / CHUNK_W;
  localparam int IDX_W = idx_w(NCHUNK);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NCHUNK - 1);
  localparam int MSB = TOTAL_W - 1;

  state_t r_state;
  state_t w_next;

  logic [TOTAL_W-1:0] r_a;
  logic [TOTAL_W-1:0] r_b;
  logic [TOTAL_W-1:0] r_sum;
  logic [TOTAL_W-1:0] r_acc;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic               r_accf;
  logic               r_cout;
  logic               r_ovf;

  logic [CHUNK_W-1:0] w_a_c;
  logic [CHUNK_W-1:0] w_b_c;
  logic [CHUNK_W-1:0] w_s_c;
  logic               w_co;
  logic [TOTAL_W-1:0] w_full;
  logic               w_accept;
  logic               w_last;

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;
  assign out_ovf   = r_ovf;
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_idx == LAST);

  // Select the active chunk of both operands.
  always_comb begin
    w_a_c = r_a[int'(r_idx)*CHUNK_W +: CHUNK_W];
    w_b_c = r_b[int'(r_idx)*CHUNK_W +: CHUNK_W];
  end

  rca_seq_accum_rca #(
    .WIDTH(CHUNK_W)
  ) u_rca (
    .i_a   (w_a_c),
    .i_b   (w_b_c),
    .i_cin (r_carry),
    .o_sum (w_s_c),
    .o_cout(w_co)
  );

  // Merge the fresh chunk into the partial result.
  always_comb begin
    w_full = r_sum;
    w_full[int'(r_idx)*CHUNK_W +: CHUNK_W] = w_s_c;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next = S_RUN;
      S_RUN:  if (w_last) w_next = S_DONE;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Operand latch, chunk stepping, flags and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_accf  <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= in_acc ? (acc_clr ? '0 : r_acc) : in_a;
            r_b     <= in_sub ? ~in_b : in_b;
            r_carry <= in_sub;
            r_accf  <= in_acc;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          r_sum   <= w_full;
          r_carry <= w_co;
          r_idx   <= r_idx + IDX_W'(1);
          if (w_last) begin
            r_cout <= w_co;
            r_ovf  <= (r_a[MSB] == r_b[MSB]) &&
                      (w_s_c[CHUNK_W-1] != r_a[MSB]);
          end
        end
        default: ;
      endcase
      if (acc_clr)
        r_acc <= '0;
      else if (r_state == S_RUN && w_last && r_accf)
        r_acc <= w_full;
    end
  end

endmodule

// File: tb/tb_rca_seq_accum.sv
// Self-checking bench for rca_seq_accum.
// Directed corner cases plus random ops against an arithmetic model.
module tb_rca_seq_accum;

  localparam int W  = 32;
  localparam int NC = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         in_acc;
  logic         acc_clr;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         busy;

  int n_chk = 0;
  int n_err = 0;
  logic [W-1:0] m_acc;

  always #5 clk = ~clk;

  rca_seq_accum #(
    .TOTAL_W(W),
    .CHUNK_W(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_sub   (in_sub),
    .in_acc   (in_acc),
    .acc_clr  (acc_clr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void ref_op(input logic [W-1:0] a, b, input bit sub,
                                 output logic [W-1:0] s, output bit co,
                                 output bit ov);
    longint sr;
    if (sub) begin
      s  = a - b;
      co = (a >= b);
      sr = longint'($signed(a)) - longint'($signed(b));
    end else begin
      s  = a + b;
      co = ({32'b0, a} + {32'b0, b}) > 64'hFFFF_FFFF;
      sr = longint'($signed(a)) + longint'($signed(b));
    end
    ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
  endfunction

  task automatic run_op(input string tag, input logic [W-1:0] a, b,
                        input bit sub, acc, clr_acc, clr_wb,
                        input int hold);
    logic [W-1:0] ea, es;
    bit ec, eo, got;
    int n;
    ea = acc ? (clr_acc ? '0 : m_acc) : a;
    ref_op(ea, b, sub, es, ec, eo);
    in_a = a; in_b = b; in_sub = sub; in_acc = acc;
    acc_clr = clr_acc; in_valid = 1'b1;
    check({tag, ".in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom; in_sub = $urandom_range(0, 1);
    if (clr_acc) m_acc = '0;
    n = 0; got = 0;
    while (!got && n < 12) begin
      acc_clr = clr_wb && (n == NC - 1);
      @(posedge clk); #1;
      n++;
      check({tag, ".busy"}, busy, 1);
      got = out_valid;
    end
    acc_clr = 1'b0;
    check({tag, ".latency"}, n, NC);
    check({tag, ".sum"}, out_sum, es);
    check({tag, ".cout"}, out_cout, ec);
    check({tag, ".ovf"}, out_ovf, eo);
    if (clr_wb) m_acc = '0;
    else if (acc) m_acc = es;
    for (int i = 0; i < hold; i++) begin
      in_valid = ~in_valid;
      in_a = $urandom; in_b = $urandom;
      @(posedge clk); #1;
      check({tag, ".hold_sum"}, out_sum, es);
      check({tag, ".hold_rdy"}, in_ready, 0);
      check({tag, ".hold_vld"}, out_valid, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".release_vld"}, out_valid, 0);
    check({tag, ".release_rdy"}, in_ready, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst = 1'b1; in_valid = 0; in_a = '0; in_b = '0; in_sub = 0;
    in_acc = 0; acc_clr = 0; out_ready = 0; m_acc = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready", in_ready, 0);
    check("rst.out_valid", out_valid, 0);
    check("rst.busy", busy, 0);
    check("rst.out_sum", out_sum, 0);
    check("rst.cout", out_cout, 0);
    check("rst.ovf", out_ovf, 0);
    rst = 1'b0;
    #1;
    check("idle.in_ready", in_ready, 1);

    run_op("carry", 32'h00FF_FFFF, 32'h1, 0, 0, 0, 0, 0);
    run_op("sub57", 32'd5, 32'd7, 1, 0, 0, 0, 0);
    run_op("sub75", 32'd7, 32'd5, 1, 0, 0, 0, 0);
    run_op("ovf_pos", 32'h7FFF_FFFF, 32'h1, 0, 0, 0, 0, 0);
    run_op("wrap", 32'hFFFF_FFFF, 32'h1, 0, 0, 0, 0, 0);
    run_op("ovf_neg", 32'h8000_0000, 32'h1, 1, 0, 0, 0, 0);

    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    m_acc = '0;
    run_op("acc10", '0, 32'd10, 0, 1, 0, 0, 0);
    run_op("acc20", '0, 32'd10, 0, 1, 0, 0, 0);
    run_op("acc30", '0, 32'd10, 0, 1, 0, 0, 0);
    run_op("acc_wbclr", '0, 32'd5, 0, 1, 0, 1, 0);
    run_op("acc_zero", '0, 32'd0, 0, 1, 0, 0, 0);
    run_op("acc_clr3", '0, 32'd3, 0, 1, 1, 0, 0);
    run_op("acc_after3", '0, 32'd0, 0, 1, 0, 0, 0);

    run_op("bp", 32'h1234_5678, 32'h0101_0101, 0, 0, 0, 0, 5);

    in_a = 32'h0F0F_0F0F; in_b = 32'h1111_1111; in_sub = 0;
    in_acc = 0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rstrun.in_ready", in_ready, 0);
    @(posedge clk); #1;
    check("rstrun.out_valid", out_valid, 0);
    check("rstrun.busy", busy, 0);
    check("rstrun.out_sum", out_sum, 0);
    check("rstrun.cout", out_cout, 0);
    check("rstrun.ovf", out_ovf, 0);
    rst = 1'b0;
    m_acc = '0;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check("rstrun.no_valid", seen, 0);
    run_op("post_rst", 32'd1, 32'd2, 0, 0, 0, 0, 0);
    run_op("post_rst_acc", '0, 32'd0, 0, 1, 0, 0, 0);

    for (int k = 0; k < 24; k++) begin
      bit s, ac, cl, cw;
      s  = $urandom_range(0, 1);
      ac = $urandom_range(0, 2) == 0;
      cl = $urandom_range(0, 5) == 0;
      cw = $urandom_range(0, 5) == 0;
      run_op("rand", $urandom, $urandom, s, ac, cl, cw,
             $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
